// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program run controller.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [8:0] HALT_OP = 9'b111111111;

  localparam int unsigned PROG_COUNT = 3;
  localparam logic [9:0] PROG_START [PROG_COUNT] = '{10'd0, 10'd256, 10'd512};

  // Start address lookup; indices beyond the table map to address 0.
  function automatic logic [9:0] prog_start(input logic [1:0] idx);
    logic [9:0] addr;
    addr = '0;
    case (idx)
      2'd0:    addr = PROG_START[0];
      2'd1:    addr = PROG_START[1];
      2'd2:    addr = PROG_START[2];
      default: addr = '0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Run controller for instruction fetch: launches programs from a fixed start
// table on Start rising edges, runs until HALT or watchdog, then holds the PC.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned NUM_PROGS  = 3,
  parameter int unsigned PC_W       = 10,
  parameter int unsigned INST_W     = 9,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 1023
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [INST_W-1:0] InstOut,
  output logic              PcLoad,
  output logic              PcHold,
  output logic [PC_W-1:0]   Target,
  output logic [1:0]        ProgIdx,
  output logic              Busy,
  output logic              Done,
  output logic              Timeout,
  output logic [CNT_W-1:0]  CycleCount
);

  state_e     state_d, state_q;
  logic [1:0] prog_idx_d, prog_idx_q;
  logic       timeout_d, timeout_q;
  logic       start_d, start_q;

  logic       start_rise;
  logic       halt;
  logic       watchdog;
  logic [1:0] next_idx;
  logic       cnt_clear;
  logic       cnt_en;

  // Launch detection, termination conditions and program index wrap.
  always_comb begin
    start_d    = Start;
    start_rise = Start & ~start_q;
    halt       = (InstOut == INST_W'(HALT_OP));
    watchdog   = (CycleCount == CNT_W'(MAX_CYCLES - 1));
    next_idx   = (prog_idx_q == 2'(NUM_PROGS - 1)) ? 2'd0 : prog_idx_q + 2'd1;
  end

  // Sequencer next-state: HALT takes priority over the watchdog.
  always_comb begin
    state_d    = state_q;
    prog_idx_d = prog_idx_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      IDLE: if (start_rise) state_d = LOAD;
      LOAD: begin
        timeout_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        if (halt) begin
          state_d    = DONE;
          prog_idx_d = next_idx;
        end else if (watchdog) begin
          state_d    = DONE;
          timeout_d  = 1'b1;
          prog_idx_d = next_idx;
        end
      end
      DONE: if (start_rise) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      prog_idx_q <= '0;
      timeout_q  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_idx_q <= prog_idx_d;
      timeout_q  <= timeout_d;
      start_q    <= start_d;
    end
  end

  assign cnt_clear = (state_q == LOAD);
  assign cnt_en    = (state_q == RUN);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cycle_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .clear (cnt_clear),
    .enable(cnt_en),
    .count (CycleCount)
  );

  // Outputs decoded purely from registered state.
  always_comb begin
    PcLoad  = (state_q == LOAD);
    PcHold  = (state_q == IDLE) || (state_q == DONE);
    Busy    = (state_q == LOAD) || (state_q == RUN);
    Done    = (state_q == DONE);
    Timeout = timeout_q;
    ProgIdx = prog_idx_q;
    Target  = PC_W'(prog_start(prog_idx_q));
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer (watchdog shortened to 8 cycles).
module tb_prog_sequencer;

  localparam logic [8:0] H   = 9'h1FF;
  localparam logic [8:0] NOP = 9'h000;

  typedef struct packed {
    logic        pl;
    logic        ph;
    logic        busy;
    logic        done;
    logic        to;
    logic [1:0]  idx;
    logic [9:0]  tgt;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic       start;
    logic [8:0] inst;
    exp_t       exp;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [8:0]  InstOut = '0;
  logic        PcLoad, PcHold, Busy, Done, Timeout;
  logic [9:0]  Target;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t vecs[17];

  prog_sequencer #(
    .NUM_PROGS (3),
    .PC_W      (10),
    .INST_W    (9),
    .CNT_W     (16),
    .MAX_CYCLES(8)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .InstOut   (InstOut),
    .PcLoad    (PcLoad),
    .PcHold    (PcHold),
    .Target    (Target),
    .ProgIdx   (ProgIdx),
    .Busy      (Busy),
    .Done      (Done),
    .Timeout   (Timeout),
    .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t actual();
    return '{PcLoad, PcHold, Busy, Done, Timeout, ProgIdx, Target, CycleCount};
  endfunction

  function automatic exp_t mk(input logic pl, ph, b, d, to, input logic [1:0] idx,
                              input logic [9:0] tgt, input logic [15:0] cnt);
    return '{pl, ph, b, d, to, idx, tgt, cnt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic s, input logic [8:0] i);
    @(negedge Clk);
    Start   = s;
    InstOut = i;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int pulses;
    exp_t e;

    //               start inst  pl ph b  d  to idx tgt   cnt
    vecs[0]  = '{1'b0, NOP, mk(0, 1, 0, 0, 0, 0, 0,   0)};  // idle
    vecs[1]  = '{1'b1, NOP, mk(1, 0, 1, 0, 0, 0, 0,   0)};  // load prog 0
    vecs[2]  = '{1'b0, NOP, mk(0, 0, 1, 0, 0, 0, 0,   0)};  // run entered
    vecs[3]  = '{1'b0, NOP, mk(0, 0, 1, 0, 0, 0, 0,   1)};
    vecs[4]  = '{1'b0, NOP, mk(0, 0, 1, 0, 0, 0, 0,   2)};
    vecs[5]  = '{1'b0, NOP, mk(0, 0, 1, 0, 0, 0, 0,   3)};
    vecs[6]  = '{1'b0, NOP, mk(0, 0, 1, 0, 0, 0, 0,   4)};
    vecs[7]  = '{1'b0, H,   mk(0, 1, 0, 1, 0, 1, 256, 5)};  // HALT on 5th run cycle
    vecs[8]  = '{1'b0, NOP, mk(0, 1, 0, 1, 0, 1, 256, 5)};
    vecs[9]  = '{1'b1, NOP, mk(1, 0, 1, 0, 0, 1, 256, 5)};  // load prog 1
    vecs[10] = '{1'b1, H,   mk(0, 0, 1, 0, 0, 1, 256, 0)};  // HALT ignored in LOAD
    vecs[11] = '{1'b1, H,   mk(0, 1, 0, 1, 0, 2, 512, 1)};
    vecs[12] = '{1'b1, NOP, mk(0, 1, 0, 1, 0, 2, 512, 1)};  // held Start, no relaunch
    vecs[13] = '{1'b0, NOP, mk(0, 1, 0, 1, 0, 2, 512, 1)};
    vecs[14] = '{1'b1, NOP, mk(1, 0, 1, 0, 0, 2, 512, 1)};  // load prog 2
    vecs[15] = '{1'b0, NOP, mk(0, 0, 1, 0, 0, 2, 512, 0)};
    vecs[16] = '{1'b0, H,   mk(0, 1, 0, 1, 0, 0, 0,   1)};  // index wraps to 0

    #3;
    chk("reset_state", 64'(actual()), 64'(mk(0, 1, 0, 0, 0, 0, 0, 0)));
    @(negedge Clk);
    Reset = 1'b1;

    foreach (vecs[k]) begin
      sb.push_back(vecs[k].exp);
      step(vecs[k].start, vecs[k].inst);
      e = sb.pop_front();
      chk($sformatf("vec%0d", k), 64'(actual()), 64'(e));
    end

    // Start held high from DONE: one launch, then watchdog ends the run.
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, NOP);
      if (PcLoad) pulses++;
    end
    chk("held_start_pulses", 64'(pulses), 64'd1);
    chk("watchdog_done", 64'(Done), 64'd1);
    chk("watchdog_timeout", 64'(Timeout), 64'd1);
    chk("watchdog_count", 64'(CycleCount), 64'd8);
    chk("watchdog_idx", 64'(ProgIdx), 64'd1);

    // HALT coincident with the watchdog cycle: HALT wins.
    step(1'b0, NOP);
    step(1'b1, NOP);
    chk("relaunch_load", 64'(PcLoad), 64'd1);
    step(1'b0, NOP);
    chk("timeout_cleared", 64'(Timeout), 64'd0);
    for (int c = 0; c < 7; c++) step(1'b0, NOP);
    step(1'b0, H);
    chk("halt_vs_wd", 64'(actual()), 64'(mk(0, 1, 0, 1, 0, 2, 512, 8)));

    // Asynchronous reset in the middle of a run.
    step(1'b0, NOP);
    step(1'b1, NOP);
    step(1'b0, NOP);
    for (int c = 0; c < 3; c++) step(1'b0, NOP);
    chk("pre_reset_run", 64'(actual()), 64'(mk(0, 0, 1, 0, 0, 2, 512, 3)));
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("async_reset", 64'(actual()), 64'(mk(0, 1, 0, 0, 0, 0, 0, 0)));
    @(negedge Clk);
    Reset = 1'b1;
    step(1'b0, NOP);
    chk("post_reset_idle", 64'(actual()), 64'(mk(0, 1, 0, 0, 0, 0, 0, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
